// File: rtl/vc_dest_arbiter_if.sv
// ----------------------------------------------------------------------------
// vc_dest_arbiter_if
// Purpose : groups the VC-FIFO, destination-FIFO and status signals of the
//           VC-to-destination arbiter into one bundle.
// Signals :
//   active_in        parent FSM is in ACTIVE (pops allowed)
//   vc0/vc1_empty    virtual-channel FIFO empty flags
//   vc0/vc1_data     VC FIFO registered read data (valid the cycle after pop)
//   d0/d1_almost_full destination FIFO threshold flags
//   pop_vc0/pop_vc1  combinational pop strobes to the VC FIFOs
//   data_out         registered word shared by D0 and D1
//   push_d0/push_d1  registered push strobes to the destination FIFOs
//   arb_state        registered FSM state (0 IDLE, 1 ACTIVE, 2 STALL)
//   idle_out         registered; no pops pending and pipeline empty
// Modports: master = environment / parent side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface vc_dest_arbiter_if #(
  parameter int unsigned DW = 6
);
  logic          active_in;
  logic          vc0_empty;
  logic          vc1_empty;
  logic [DW-1:0] vc0_data;
  logic [DW-1:0] vc1_data;
  logic          d0_almost_full;
  logic          d1_almost_full;
  logic          pop_vc0;
  logic          pop_vc1;
  logic [DW-1:0] data_out;
  logic          push_d0;
  logic          push_d1;
  logic [1:0]    arb_state;
  logic          idle_out;

  modport master (
    output active_in, vc0_empty, vc1_empty, vc0_data, vc1_data,
           d0_almost_full, d1_almost_full,
    input  pop_vc0, pop_vc1, data_out, push_d0, push_d1, arb_state, idle_out
  );

  modport slave (
    input  active_in, vc0_empty, vc1_empty, vc0_data, vc1_data,
           d0_almost_full, d1_almost_full,
    output pop_vc0, pop_vc1, data_out, push_d0, push_d1, arb_state, idle_out
  );
endinterface

// File: rtl/vc_dest_arbiter.sv
// ----------------------------------------------------------------------------
// vc_dest_arbiter
// Purpose : pops the two virtual-channel FIFOs with weighted round-robin and
//           routes each popped word to destination FIFO D0 or D1 by its
//           DEST_BIT. Pop-to-push latency is two cycles; pops are throttled by
//           the destination almost-full flags and the parent ACTIVE state.
// Ports   :
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    vc_dest_arbiter_if.slave (see interface header for signal list)
// ----------------------------------------------------------------------------
module vc_dest_arbiter #(
  parameter int unsigned DW         = 6,
  parameter int unsigned DEST_BIT   = 4,
  parameter int unsigned VC0_WEIGHT = 4
) (
  input  logic               clk,
  input  logic               reset,
  vc_dest_arbiter_if.slave   bus
);

  localparam int unsigned WCNT_W = 4;
  localparam logic [WCNT_W-1:0] WEIGHT = WCNT_W'(VC0_WEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  // Arbitration / qualification
  logic              w_any_af;
  logic              w_any_vc;
  logic              w_can_pop;
  logic              w_grant_vc1;
  logic              w_pop_vc0;
  logic              w_pop_vc1;
  logic              w_pop;
  logic [WCNT_W-1:0] w_wcnt_next;

  // Pipeline
  logic              r_v1;
  logic              r_src1;
  logic [DW-1:0]     w_stage1_data;
  logic              w_dest;

  // Registered outputs and state
  logic [WCNT_W-1:0] r_wcnt;
  logic [DW-1:0]     r_data_out;
  logic              r_push_d0;
  logic              r_push_d1;
  logic              r_idle_out;
  logic              w_idle_next;
  state_t            r_state;
  state_t            w_state_next;

  // Pop qualification and weighted round-robin grant
  always_comb begin
    w_any_af  = bus.d0_almost_full | bus.d1_almost_full;
    w_any_vc  = ~bus.vc0_empty | ~bus.vc1_empty;
    w_can_pop = bus.active_in & ~w_any_af & ~reset;

    w_grant_vc1 = 1'b0;
    if (bus.vc1_empty) begin
      w_grant_vc1 = 1'b0;
    end else if (bus.vc0_empty) begin
      w_grant_vc1 = 1'b1;
    end else begin
      // VC1 only wins a contended cycle once VC0 used up its weight
      w_grant_vc1 = (r_wcnt == WEIGHT);
    end

    w_pop_vc0 = w_can_pop & ~bus.vc0_empty & ~w_grant_vc1;
    w_pop_vc1 = w_can_pop & ~bus.vc1_empty &  w_grant_vc1;
    w_pop     = w_pop_vc0 | w_pop_vc1;
  end

  // Weight counter next value: counts VC0 grants only while VC1 is waiting
  always_comb begin
    w_wcnt_next = r_wcnt;
    if (w_pop_vc0) begin
      if (!bus.vc1_empty) begin
        if (r_wcnt < WEIGHT) begin
          w_wcnt_next = r_wcnt + WCNT_W'(1);
        end
      end else begin
        w_wcnt_next = '0;
      end
    end else if (w_pop_vc1) begin
      w_wcnt_next = '0;
    end
  end

  // Next-state logic and registered-status next values
  always_comb begin
    w_state_next = ST_IDLE;
    w_idle_next  = 1'b0;
    if (w_pop) begin
      w_state_next = ST_ACTIVE;
    end else if (bus.active_in && w_any_vc && w_any_af) begin
      w_state_next = ST_STALL;
    end else begin
      w_state_next = ST_IDLE;
    end
    // A word in stage 1 will still push next cycle, so not idle yet
    w_idle_next = (w_state_next == ST_IDLE) & ~r_v1;
  end

  // Stage-1 read-data select; the VC FIFO presents data the cycle after pop
  always_comb begin
    w_stage1_data = r_src1 ? bus.vc1_data : bus.vc0_data;
    w_dest        = w_stage1_data[DEST_BIT];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Weight counter, pipeline and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt     <= '0;
      r_v1       <= 1'b0;
      r_src1     <= 1'b0;
      r_data_out <= '0;
      r_push_d0  <= 1'b0;
      r_push_d1  <= 1'b0;
      r_idle_out <= 1'b1;
    end else begin
      r_wcnt     <= w_wcnt_next;
      r_v1       <= w_pop;
      r_src1     <= w_pop_vc1;
      r_push_d0  <= r_v1 & ~w_dest;
      r_push_d1  <= r_v1 &  w_dest;
      r_idle_out <= w_idle_next;
      // data_out holds its last pushed word between pushes
      if (r_v1) begin
        r_data_out <= w_stage1_data;
      end
    end
  end

  assign bus.pop_vc0   = w_pop_vc0;
  assign bus.pop_vc1   = w_pop_vc1;
  assign bus.data_out  = r_data_out;
  assign bus.push_d0   = r_push_d0;
  assign bus.push_d1   = r_push_d1;
  assign bus.arb_state = r_state;
  assign bus.idle_out  = r_idle_out;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
module tb_vc_dest_arbiter;

  localparam int unsigned DW       = 6;
  localparam int unsigned DEST_BIT = 4;
  localparam int unsigned WGT      = 4;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          dest;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  vc_dest_arbiter_if #(.DW(DW)) bus ();

  vc_dest_arbiter #(
    .DW(DW), .DEST_BIT(DEST_BIT), .VC0_WEIGHT(WGT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  exp_t          sb[$];
  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];

  // Reference-model state
  int            mw        = 0;     // consecutive VC0 grants while VC1 waited
  logic          prev_pop  = 1'b0;
  logic [1:0]    exp_state = 2'd0;
  logic          exp_idle  = 1'b1;
  logic          pend0     = 1'b0;
  logic          pend1     = 1'b0;
  logic [DW-1:0] pend0_w   = '0;
  logic [DW-1:0] pend1_w   = '0;
  logic [DW-1:0] exp_dout  = '0;
  exp_t          e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: compares registered outputs after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        sb.delete();
        exp_dout = '0;
        chk("rst_push", {30'd0, bus.push_d1, bus.push_d0}, 32'd0);
        chk("rst_dout", 32'(bus.data_out), 32'd0);
      end else begin
        chk("push_excl", 32'(bus.push_d0 & bus.push_d1), 32'd0);
        if (bus.push_d0 || bus.push_d1) begin
          if (sb.size() == 0) begin
            chk("unexpected_push", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("push_cycle", 32'(cyc), 32'(e.due));
            chk("push_data", 32'(bus.data_out), 32'(e.data));
            chk("push_dest_d1", 32'(bus.push_d1), 32'(e.dest));
            exp_dout = e.data;
          end
        end else begin
          if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("missing_push", 32'd0, 32'd1);
            void'(sb.pop_front());
          end
          chk("dout_hold", 32'(bus.data_out), 32'(exp_dout));
        end
      end
      chk("arb_state", 32'(bus.arb_state), 32'(exp_state));
      chk("idle_out", 32'(bus.idle_out), 32'(exp_idle));
    end
  end

  // One cycle of stimulus plus the reference-model step
  task automatic step(input logic a, input logic f0, input logic f1, input logic r);
    logic can, m0, m1, any_vc;
    exp_t t;
    @(negedge clk);
    if (pend0) bus.vc0_data = pend0_w;
    if (pend1) bus.vc1_data = pend1_w;
    reset              = r;
    bus.active_in      = a;
    bus.d0_almost_full = f0;
    bus.d1_almost_full = f1;
    bus.vc0_empty      = (vc0_q.size() == 0);
    bus.vc1_empty      = (vc1_q.size() == 0);
    #1;
    any_vc = (vc0_q.size() > 0) || (vc1_q.size() > 0);
    can = a && !f0 && !f1 && !r;
    m0  = can && (vc0_q.size() > 0) && ((vc1_q.size() == 0) || (mw != int'(WGT)));
    m1  = can && !m0 && (vc1_q.size() > 0);
    chk("pop_vc0", 32'(bus.pop_vc0), 32'(m0));
    chk("pop_vc1", 32'(bus.pop_vc1), 32'(m1));
    if (m0) begin
      t.due = cyc + 2; t.data = vc0_q[0]; t.dest = vc0_q[0][DEST_BIT];
      sb.push_back(t);
      mw = (vc1_q.size() > 0) ? ((mw < int'(WGT)) ? mw + 1 : mw) : 0;
    end
    if (m1) begin
      t.due = cyc + 2; t.data = vc1_q[0]; t.dest = vc1_q[0][DEST_BIT];
      sb.push_back(t);
      mw = 0;
    end
    if (r) mw = 0;
    // VC FIFOs react to the strobes the DUT actually drives
    pend0 = bus.pop_vc0 && (vc0_q.size() > 0);
    pend1 = bus.pop_vc1 && (vc1_q.size() > 0);
    if (pend0) pend0_w = vc0_q.pop_front();
    if (pend1) pend1_w = vc1_q.pop_front();
    if (r)                             exp_state = 2'd0;
    else if (m0 || m1)                 exp_state = 2'd1;
    else if (a && any_vc && (f0 || f1)) exp_state = 2'd2;
    else                               exp_state = 2'd0;
    exp_idle = r ? 1'b1 : ((exp_state == 2'd0) && !prev_pop);
    prev_pop = r ? 1'b0 : (m0 || m1);
  endtask

  task automatic fill(input int n0, input int n1);
    for (int i = 0; i < n0; i++) vc0_q.push_back(DW'($urandom));
    for (int i = 0; i < n1; i++) vc1_q.push_back(DW'($urandom));
  endtask

  initial begin
    reset              = 1'b1;
    bus.active_in      = 1'b1;
    bus.vc0_empty      = 1'b1;
    bus.vc1_empty      = 1'b1;
    bus.vc0_data       = '0;
    bus.vc1_data       = '0;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;

    // Reset with both VCs non-empty and active_in high
    vc0_q.push_back(6'h05); vc0_q.push_back(6'h12); vc0_q.push_back(6'h1A);
    vc1_q.push_back(6'h2A);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    vc1_q.delete();
    step(1'b1, 1'b0, 1'b0, 1'b1);

    // VC0-only stream of three words
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Weighted round-robin with both VCs loaded
    fill(10, 10);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Almost-full throttle in the middle of a stream
    fill(20, 20);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // active_in drops mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset right after a pop, then grant order restarts from zero weight
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 45) vc0_q.push_back(DW'($urandom));
      if ($urandom_range(0, 99) < 35) vc1_q.push_back(DW'($urandom));
      step($urandom_range(0, 99) < 90,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 1);
    end

    // Drain, bounded
    for (int i = 0; i < 400 && (vc0_q.size() > 0 || vc1_q.size() > 0); i++)
      step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("vc_drained", 32'(vc0_q.size() + vc1_q.size()), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_dest_arbiter.md
Name: vc_dest_arbiter

Overview:
- Sequences the transaction-layer datapath between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1).
- Selects a non-empty VC with weighted round-robin and pops it.
- Routes the popped word to D0 or D1 by its destination bit.
- Throttles on destination almost-full flags and only issues pops while the parent FSM reports ACTIVE.

Parameters:
- DW, 6, data word width (matches data_in[5:0]).
- DEST_BIT, 4, bit index of the word that selects the destination: 0 selects D0, 1 selects D1.
- VC0_WEIGHT, 4, maximum consecutive VC0 grants while VC1 is non-empty; range 1..15.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- active_in  in  1  parent FSM in ACTIVE; new pops are allowed only while this is high.
- vc0_empty  in  1  VC0 FIFO empty.
- vc1_empty  in  1  VC1 FIFO empty.
- vc0_data  in  DW  VC0 FIFO registered read data; valid in the cycle after pop_vc0.
- vc1_data  in  DW  VC1 FIFO registered read data; valid in the cycle after pop_vc1.
- d0_almost_full  in  1  D0 FIFO at or above its threshold (UD).
- d1_almost_full  in  1  D1 FIFO at or above its threshold (UD).
- pop_vc0  out  1  combinational pop strobe to VC0.
- pop_vc1  out  1  combinational pop strobe to VC1.
- data_out  out  DW  registered word shared by D0 and D1.
- push_d0  out  1  registered push strobe to D0.
- push_d1  out  1  registered push strobe to D1.
- arb_state  out  2  registered FSM state: 0 IDLE, 1 ACTIVE, 2 STALL.
- idle_out  out  1  registered; high when no pops are pending and the pipeline is empty.

Behaviour:
- Reset (synchronous): the following are cleared on the first clock edge with reset high; while reset stays high no pop is issued.
  - data_out=0, push_d0=0, push_d1=0, arb_state=IDLE, idle_out=1.
  - Weight counter=0; pipeline valid bits=0.
- Pop qualification, combinational in cycle N: can_pop = active_in & ~d0_almost_full & ~d1_almost_full & ~reset. At most one pop per cycle.
- Grant rule:
  - If VC1 is empty, grant VC0.
  - If VC0 is empty, grant VC1.
  - If both are non-empty, grant VC1 when wcnt==VC0_WEIGHT, otherwise grant VC0.
- Weight counter (wcnt, 4 bits), updated only on a pop:
  - VC0 pop with VC1 non-empty: wcnt+1, saturating at VC0_WEIGHT.
  - VC0 pop with VC1 empty: wcnt=0.
  - VC1 pop: wcnt=0.
- Pipeline:
  - Pop in cycle N sets stage-1 valid and source (v1, src1) at the end of N.
  - In cycle N+1 the arbiter selects vc0_data or vc1_data by src1.
  - At the end of N+1 it registers data_out and push_d0/push_d1 from bit DEST_BIT.
  - Push is high in cycle N+2, for exactly one cycle per popped word. Pop-to-push latency is 2 cycles.
  - Back-to-back pops give back-to-back pushes; word order within a VC is preserved.
- In-flight margin: up to 2 words can be in flight when an almost_full flag rises. Destination thresholds must leave at least 3 free entries; the arbiter does not track D occupancy.
- push_d0 and push_d1 are never high together. data_out holds its last value when no push occurs.
- FSM, next state registered each cycle:
  - ACTIVE if a pop is issued this cycle.
  - Else STALL if active_in is high, some VC is non-empty and an almost_full flag is high.
  - Else IDLE.
- idle_out = next state IDLE & ~v1 & ~push pending.
- active_in falling mid-stream: no new pops from that cycle on; the words already in flight still complete their pushes.
- reset mid-operation: in-flight words are discarded and no push occurs in the cycle after reset. Words already popped from the VC FIFOs are lost; the parent resets the FIFOs at the same time.
- almost_full asserted in the same cycle as a candidate pop: the pop is suppressed in that cycle.

Test Plan:
- Reset held 2 cycles with both VCs non-empty and active_in=1 -> pop_vc0=pop_vc1=0 throughout; push_d0=push_d1=0, data_out=0, arb_state=0, idle_out=1.
- VC0 holds 0x05, 0x12, 0x1A; VC1 empty; active_in=1 -> pop_vc0 in cycles 1-3; push_d0 with data_out=0x05 in cycle 3; push_d1 with 0x12 in cycle 4; push_d1 with 0x1A in cycle 5; idle_out=1 in cycle 6.
- Both VCs hold 10 words; VC0_WEIGHT=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1,…; no idle cycles between pops.
- Continuous pops; d1_almost_full=1 in cycle 5 -> no pop in cycle 5; at most 2 pushes in cycles 5-6; arb_state=STALL from cycle 6; d1_almost_full=0 in cycle 9 -> pop in cycle 9, arb_state=ACTIVE in cycle 10.
- active_in drops in cycle 4 of a stream -> last pop in cycle 3; last push in cycle 5; arb_state=IDLE and idle_out=1 by cycle 6.
- reset asserted in the cycle after a pop -> no push in the following cycle; all outputs at reset values; wcnt=0, verified by the next grant order after release.
